fwd_scoreboard_unit: RTL and testbench

//  Parametrised operand-forwarding and hazard unit for the EX stage of the pipelined RISC-V core.
//  Per source operand: bypass select with priority MEM > WB > regfile, plus a load-use stall.

---
 rtl/fwd_scoreboard_unit_if.sv | 40 ++++
 rtl/fwd_scoreboard_unit.sv | 92 +++++++++
 tb/tb_fwd_scoreboard_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_unit_if.sv
// Bundle of EX-stage hazard inputs and forwarding/stall outputs for fwd_scoreboard_unit.
// The slave modport is the unit itself; the master modport is the pipeline driving it.
interface fwd_scoreboard_unit_if #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = 16
);
    localparam int PCW = $clog2(PEND_DEPTH + 1);

    logic                      ex_valid_i;
    logic [NUM_SRC*REG_AW-1:0] rs_i;
    logic [REG_AW-1:0]         mem_rd_i;
    logic                      mem_regwrite_i;
    logic                      mem_is_load_i;
    logic [REG_AW-1:0]         wb_rd_i;
    logic                      wb_regwrite_i;
    logic                      lop_issue_i;
    logic [REG_AW-1:0]         lop_rd_i;
    logic                      lop_done_i;
    logic [REG_AW-1:0]         lop_done_rd_i;
    logic [NUM_SRC*2-1:0]      fwd_sel_o;
    logic                      stall_o;
    logic [PCW-1:0]            pend_cnt_o;
    logic                      pend_full_o;
    logic [CNT_W-1:0]          stall_cnt_o;
    logic                      err_o;

    modport slave (
        input  ex_valid_i, rs_i, mem_rd_i, mem_regwrite_i, mem_is_load_i,
        input  wb_rd_i, wb_regwrite_i, lop_issue_i, lop_rd_i, lop_done_i, lop_done_rd_i,
        output fwd_sel_o, stall_o, pend_cnt_o, pend_full_o, stall_cnt_o, err_o
    );

    modport master (
        output ex_valid_i, rs_i, mem_rd_i, mem_regwrite_i, mem_is_load_i,
        output wb_rd_i, wb_regwrite_i, lop_issue_i, lop_rd_i, lop_done_i, lop_done_rd_i,
        input  fwd_sel_o, stall_o, pend_cnt_o, pend_full_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// EX-stage operand forwarding, load-use stall and busy-bit scoreboard for long-latency writers.
// The interface instance must be built with the same parameter values as this module.
module fwd_scoreboard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fwd_scoreboard_unit_if.slave  bus
);
    localparam int NREG = 2 ** REG_AW;
    localparam int PCW  = $clog2(PEND_DEPTH + 1);

    logic [NREG-1:0]      r_busy;
    logic [PCW-1:0]       r_pend_cnt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic                 r_err;

    logic [NREG-1:0]      w_busy_nxt;
    logic [NUM_SRC*2-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]   w_hit;
    logic                 w_full;
    logic                 w_dv;
    logic                 w_stall;
    logic                 w_acc;
    logic                 w_waw;
    logic                 w_inc;

    assign w_full = (r_pend_cnt == PCW'(PEND_DEPTH));
    assign w_dv   = bus.lop_done_i && (bus.lop_done_rd_i != '0) && r_busy[bus.lop_done_rd_i];

    always_comb begin
        w_fwd_sel = '0;
        w_hit     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.mem_regwrite_i && (bus.mem_rd_i != '0) &&
                (bus.mem_rd_i == bus.rs_i[k*REG_AW +: REG_AW]))
                w_fwd_sel[k*2 +: 2] = 2'b10;
            else if (bus.wb_regwrite_i && (bus.wb_rd_i != '0) &&
                     (bus.wb_rd_i == bus.rs_i[k*REG_AW +: REG_AW]))
                w_fwd_sel[k*2 +: 2] = 2'b01;
            // A completing op is forwarded from WB, so its busy bit no longer blocks.
            w_hit[k] = (bus.rs_i[k*REG_AW +: REG_AW] != '0) &&
                       ((r_busy[bus.rs_i[k*REG_AW +: REG_AW]] &&
                         !(bus.lop_done_i && (bus.lop_done_rd_i == bus.rs_i[k*REG_AW +: REG_AW]))) ||
                        (bus.mem_regwrite_i && bus.mem_is_load_i &&
                         (bus.mem_rd_i == bus.rs_i[k*REG_AW +: REG_AW])));
        end
    end

    // A completion in the same cycle frees a slot, so a full table does not block that issue.
    assign w_stall = bus.ex_valid_i && ((|w_hit) || (bus.lop_issue_i && w_full && !w_dv));
    assign w_acc   = bus.lop_issue_i && bus.ex_valid_i && !w_stall && (bus.lop_rd_i != '0);
    assign w_waw   = r_busy[bus.lop_rd_i] && !(w_dv && (bus.lop_done_rd_i == bus.lop_rd_i));
    assign w_inc   = w_acc && !w_waw;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_dv)
            w_busy_nxt[bus.lop_done_rd_i] = 1'b0;
        if (w_acc)
            w_busy_nxt[bus.lop_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_busy      <= '0;
            r_pend_cnt  <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_inc && !w_dv)
                r_pend_cnt <= r_pend_cnt + PCW'(1);
            else if (w_dv && !w_inc)
                r_pend_cnt <= r_pend_cnt - PCW'(1);
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((bus.lop_done_i && !w_dv) || (w_acc && w_waw))
                r_err <= 1'b1;
        end
    end

    assign bus.fwd_sel_o   = w_fwd_sel;
    assign bus.stall_o     = w_stall;
    assign bus.pend_cnt_o  = r_pend_cnt;
    assign bus.pend_full_o = w_full;
    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: table vectors, hand sequences for the multi-cycle cases,
// and random traffic checked against a queue-based model of outstanding long-latency writes.
module tb_fwd_scoreboard_unit;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic clk_i;
    logic rst_i;

    fwd_scoreboard_unit_if #(.REG_AW(5), .NUM_SRC(2), .PEND_DEPTH(DEPTH), .CNT_W(CW)) bus ();

    fwd_scoreboard_unit #(.REG_AW(5), .NUM_SRC(2), .PEND_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the set of outstanding long-latency destinations, kept as a list.
    int pend_q[$];
    int m_stall_cnt;
    bit m_err;
    logic [3:0] e_fwd;
    logic       e_stall;

    typedef struct {
        logic       ev;
        logic [4:0] rs0, rs1, mem_rd;
        logic       mem_wr, mem_ld;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input int r);
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit done_ok();
        return bus.lop_done_i && bus.lop_done_rd_i != 0 && in_q(int'(bus.lop_done_rd_i));
    endfunction

    task automatic model_comb();
        bit any_hit;
        int rs;
        any_hit = 1'b0;
        e_fwd   = '0;
        for (int k = 0; k < 2; k++) begin
            rs = (k == 0) ? int'(bus.rs_i[4:0]) : int'(bus.rs_i[9:5]);
            if (bus.mem_regwrite_i && bus.mem_rd_i != 0 && int'(bus.mem_rd_i) == rs)
                e_fwd[k*2 +: 2] = 2'd2;
            else if (bus.wb_regwrite_i && bus.wb_rd_i != 0 && int'(bus.wb_rd_i) == rs)
                e_fwd[k*2 +: 2] = 2'd1;
            if (rs != 0) begin
                if (in_q(rs) && !(bus.lop_done_i && int'(bus.lop_done_rd_i) == rs)) any_hit = 1'b1;
                if (bus.mem_regwrite_i && bus.mem_is_load_i && int'(bus.mem_rd_i) == rs) any_hit = 1'b1;
            end
        end
        e_stall = bus.ex_valid_i &&
                  (any_hit || (bus.lop_issue_i && pend_q.size() == DEPTH && !done_ok()));
    endtask

    task automatic model_edge();
        int idx[$];
        if (!rst_i) begin
            pend_q.delete();
            m_stall_cnt = 0;
            m_err = 1'b0;
            return;
        end
        if (bus.lop_done_i) begin
            if (done_ok()) begin
                idx = pend_q.find_first_index(x) with (x == int'(bus.lop_done_rd_i));
                pend_q.delete(idx[0]);
            end else
                m_err = 1'b1;
        end
        if (bus.lop_issue_i && bus.ex_valid_i && !e_stall && bus.lop_rd_i != 0) begin
            if (in_q(int'(bus.lop_rd_i))) m_err = 1'b1;
            else pend_q.push_back(int'(bus.lop_rd_i));
        end
        if (e_stall && m_stall_cnt < (2 ** CW) - 1) m_stall_cnt++;
    endtask

    // Settle the current inputs and compare every output to the model.
    task automatic settle();
        #1;
        model_comb();
        chk("fwd_sel", 32'(bus.fwd_sel_o), 32'(e_fwd));
        chk("stall", 32'(bus.stall_o), 32'(e_stall));
        chk("pend_cnt", 32'(bus.pend_cnt_o), 32'(pend_q.size()));
        chk("pend_full", 32'(bus.pend_full_o), 32'(pend_q.size() == DEPTH));
        chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_stall_cnt));
        chk("err", 32'(bus.err_o), 32'(m_err));
    endtask

    task automatic clk_edge();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.ex_valid_i = 1'b0; bus.rs_i = '0;
        bus.mem_rd_i = '0; bus.mem_regwrite_i = 1'b0; bus.mem_is_load_i = 1'b0;
        bus.wb_rd_i = '0; bus.wb_regwrite_i = 1'b0;
        bus.lop_issue_i = 1'b0; bus.lop_rd_i = '0;
        bus.lop_done_i = 1'b0; bus.lop_done_rd_i = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        idle();
        bus.ex_valid_i = 1'b1; bus.lop_issue_i = 1'b1; bus.lop_rd_i = rd;
        settle();
        clk_edge();
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1, 3, 3, 3, 1, 0, 3, 1, 4'b1010, 0};
        tbl[1] = '{1, 3, 3, 0, 1, 0, 3, 1, 4'b0101, 0};
        tbl[2] = '{1, 3, 3, 0, 1, 0, 0, 1, 4'b0000, 0};
        tbl[3] = '{1, 2, 7, 7, 1, 1, 0, 0, 4'b1000, 1};
        tbl[4] = '{0, 2, 7, 7, 1, 1, 0, 0, 4'b1000, 0};
        tbl[5] = '{1, 2, 7, 7, 0, 1, 0, 0, 4'b0000, 0};
        tbl[6] = '{1, 0, 6, 0, 1, 1, 0, 0, 4'b0000, 0};
        tbl[7] = '{1, 4, 9, 1, 1, 0, 4, 1, 4'b0001, 0};

        pend_q.delete(); m_stall_cnt = 0; m_err = 1'b0;
        idle();
        rst_i = 1'b0;
        #12;
        @(negedge clk_i);
        rst_i = 1'b1;
        settle();

        // Saturation: 20 load-use stall cycles on a 4-bit counter.
        idle();
        bus.ex_valid_i = 1'b1; bus.rs_i = {5'd0, 5'd7};
        bus.mem_rd_i = 5'd7; bus.mem_regwrite_i = 1'b1; bus.mem_is_load_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (i == 10) chk("stall_cnt_mid", 32'(bus.stall_cnt_o), 32'd10);
            clk_edge();
        end
        idle();
        settle();
        chk("stall_cnt_sat", 32'(bus.stall_cnt_o), 32'd15);

        // Async reset with busy[5] set and two ops pending.
        do_reset();
        do_issue(5'd5);
        do_issue(5'd6);
        idle();
        bus.ex_valid_i = 1'b1; bus.rs_i = {5'd0, 5'd5};
        settle();
        chk("pre_rst_cnt", 32'(bus.pend_cnt_o), 32'd2);
        chk("pre_rst_stall", 32'(bus.stall_o), 32'd1);
        #2;
        rst_i = 1'b0;
        pend_q.delete(); m_stall_cnt = 0; m_err = 1'b0;
        #1;
        chk("rst_fwd", 32'(bus.fwd_sel_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_cnt", 32'(bus.pend_cnt_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle();
        bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd5;
        settle();
        clk_edge();
        idle();
        settle();
        chk("forgotten_done_err", 32'(bus.err_o), 32'd1);

        // Table vectors on an empty scoreboard.
        do_reset();
        foreach (tbl[i]) begin
            idle();
            bus.ex_valid_i = tbl[i].ev; bus.rs_i = {tbl[i].rs1, tbl[i].rs0};
            bus.mem_rd_i = tbl[i].mem_rd; bus.mem_regwrite_i = tbl[i].mem_wr;
            bus.mem_is_load_i = tbl[i].mem_ld;
            bus.wb_rd_i = tbl[i].wb_rd; bus.wb_regwrite_i = tbl[i].wb_wr;
            settle();
            chk($sformatf("tbl%0d_fwd", i), 32'(bus.fwd_sel_o), 32'(tbl[i].exp_fwd));
            chk($sformatf("tbl%0d_stall", i), 32'(bus.stall_o), 32'(tbl[i].exp_stall));
            clk_edge();
        end

        // Scoreboard: rd=9 stays busy until its completion, which forwards from WB.
        do_reset();
        do_issue(5'd9);
        idle();
        bus.ex_valid_i = 1'b1; bus.rs_i = {5'd0, 5'd9};
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("sb_busy_stall", 32'(bus.stall_o), 32'd1);
            clk_edge();
        end
        bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd9;
        bus.wb_rd_i = 5'd9; bus.wb_regwrite_i = 1'b1;
        settle();
        chk("sb_done_stall", 32'(bus.stall_o), 32'd0);
        chk("sb_done_fwd", 32'(bus.fwd_sel_o), 32'b0001);
        clk_edge();
        idle();
        bus.ex_valid_i = 1'b1; bus.rs_i = {5'd0, 5'd9};
        settle();
        chk("sb_cleared", 32'(bus.stall_o), 32'd0);
        chk("sb_cnt0", 32'(bus.pend_cnt_o), 32'd0);
        clk_edge();

        // Full table, blocked issue, then done+issue in the same cycle.
        do_reset();
        for (int r = 1; r <= 4; r++) do_issue(5'(r));
        idle();
        bus.ex_valid_i = 1'b1; bus.lop_issue_i = 1'b1; bus.lop_rd_i = 5'd5;
        settle();
        chk("full_flag", 32'(bus.pend_full_o), 32'd1);
        chk("full_stall", 32'(bus.stall_o), 32'd1);
        clk_edge();
        idle();
        bus.ex_valid_i = 1'b1; bus.rs_i = {5'd0, 5'd5};
        settle();
        chk("full_no_set", 32'(bus.stall_o), 32'd0);
        clk_edge();
        idle();
        bus.ex_valid_i = 1'b1; bus.lop_issue_i = 1'b1; bus.lop_rd_i = 5'd5;
        bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd1;
        settle();
        chk("swap_stall", 32'(bus.stall_o), 32'd0);
        clk_edge();
        idle();
        bus.ex_valid_i = 1'b1; bus.rs_i = {5'd1, 5'd5};
        settle();
        chk("swap_cnt", 32'(bus.pend_cnt_o), 32'd4);
        chk("swap_busy5", 32'(bus.stall_o), 32'd1);
        clk_edge();

        // Done to a register that is not busy.
        idle();
        bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd12;
        settle();
        clk_edge();
        idle();
        settle();
        chk("bad_done_err", 32'(bus.err_o), 32'd1);
        chk("bad_done_cnt", 32'(bus.pend_cnt_o), 32'd4);

        // Random traffic on a small register window.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            idle();
            bus.ex_valid_i = ($urandom_range(0, 3) != 0);
            bus.rs_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.mem_rd_i = 5'($urandom_range(0, 7));
            bus.mem_regwrite_i = 1'($urandom_range(0, 1));
            bus.mem_is_load_i = ($urandom_range(0, 3) == 0);
            bus.wb_rd_i = 5'($urandom_range(0, 7));
            bus.wb_regwrite_i = 1'($urandom_range(0, 1));
            bus.lop_issue_i = ($urandom_range(0, 2) == 0);
            bus.lop_rd_i = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                bus.lop_done_i = 1'b1;
                if (pend_q.size() != 0 && $urandom_range(0, 7) != 0)
                    bus.lop_done_rd_i = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
                else
                    bus.lop_done_rd_i = 5'($urandom_range(0, 7));
                bus.wb_rd_i = bus.lop_done_rd_i;
                bus.wb_regwrite_i = 1'b1;
            end
            if (i == 300) begin
                rst_i = 1'b0;
                #1;
                pend_q.delete(); m_stall_cnt = 0; m_err = 1'b0;
                @(negedge clk_i);
                rst_i = 1'b1;
            end
            settle();
            clk_edge();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
